// File: rtl/xvga_pkg.sv
// Shared raster timing constants and counter widths for the XVGA timing generator.
package xvga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } raster_timing_t;

  localparam raster_timing_t XVGA_1024x768_60 = '{
    h: '{active: 1024, fp: 24, sync: 136, bp: 160},
    v: '{active: 768,  fp: 3,  sync: 6,   bp: 29}
  };

  localparam raster_timing_t VGA_640x480_60 = '{
    h: '{active: 640, fp: 16, sync: 96, bp: 48},
    v: '{active: 480, fp: 10, sync: 2,  bp: 33}
  };

  function automatic int axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/xvga_axis.sv
// One raster axis: wrapping position counter with enable, plus registered
// active-low sync decoded from the next count so it lines up with the counter.
module xvga_axis
  import xvga_pkg::*;
#(
  parameter int ACTIVE = XVGA_1024x768_60.h.active,
  parameter int FP     = XVGA_1024x768_60.h.fp,
  parameter int SYNC   = XVGA_1024x768_60.h.sync,
  parameter int BP     = XVGA_1024x768_60.h.bp,
  parameter int W      = HCOUNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active_nxt,
  output logic         sync_n
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);

  logic [W-1:0] cnt_nxt;
  logic         at_last;

  always_comb begin
    at_last    = (cnt == LAST);
    wrap       = en & at_last;
    cnt_nxt    = cnt;
    if (en) begin
      cnt_nxt = at_last ? '0 : cnt + 1'b1;
    end
    active_nxt = (cnt_nxt < ACT_END);
  end

  // Reset parks the axis on its last position so the first enabled edge lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= LAST;
      sync_n <= 1'b1;
    end else begin
      cnt    <= cnt_nxt;
      sync_n <= !((cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI));
    end
  end

endmodule

// File: rtl/xvga_timing.sv
// XVGA 1024x768@60 raster timing generator; every output is a flop decoded from
// next-state counters. Optional frame counter enabled by `XVGA_FRAME_COUNT_EN.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int H_ACTIVE = XVGA_1024x768_60.h.active,
  parameter int H_FP     = XVGA_1024x768_60.h.fp,
  parameter int H_SYNC   = XVGA_1024x768_60.h.sync,
  parameter int H_BP     = XVGA_1024x768_60.h.bp,
  parameter int V_ACTIVE = XVGA_1024x768_60.v.active,
  parameter int V_FP     = XVGA_1024x768_60.v.fp,
  parameter int V_SYNC   = XVGA_1024x768_60.v.sync,
  parameter int V_BP     = XVGA_1024x768_60.v.bp
) (
  input  logic                vclock,
  input  logic                reset,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                blank,
  output logic                frame_start
`ifdef XVGA_FRAME_COUNT_EN
  ,
  output logic [15:0]         frame_count
`endif
);

  localparam int H_TOTAL = axis_total('{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int V_TOTAL = axis_total('{V_ACTIVE, V_FP, V_SYNC, V_BP});

  if (H_TOTAL > (1 << HCOUNT_W)) begin : g_h_too_wide
    $error("xvga_timing: H_TOTAL %0d does not fit hcount", H_TOTAL);
  end
  if (V_TOTAL > (1 << VCOUNT_W)) begin : g_v_too_wide
    $error("xvga_timing: V_TOTAL %0d does not fit vcount", V_TOTAL);
  end

  logic h_wrap;
  logic v_wrap;
  logic h_act_nxt;
  logic v_act_nxt;
  logic frame_nxt;

  xvga_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HCOUNT_W)
  ) u_h (
    .clk        (vclock),
    .rst_n      (reset),
    .en         (1'b1),
    .cnt        (hcount),
    .wrap       (h_wrap),
    .active_nxt (h_act_nxt),
    .sync_n     (hsync)
  );

  xvga_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VCOUNT_W)
  ) u_v (
    .clk        (vclock),
    .rst_n      (reset),
    .en         (h_wrap),
    .cnt        (vcount),
    .wrap       (v_wrap),
    .active_nxt (v_act_nxt),
    .sync_n     (vsync)
  );

  // Both axes wrapping together means the next position is (0,0).
  assign frame_nxt = h_wrap & v_wrap;

  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      blank       <= ~(h_act_nxt & v_act_nxt);
      frame_start <= frame_nxt;
    end
  end

`ifdef XVGA_FRAME_COUNT_EN
  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else begin
      frame_count <= frame_count + {15'd0, frame_nxt};
    end
  end
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: full-size and shrunken-geometry instances checked every
// cycle against an arithmetic raster model, with randomized async resets.
module tb_xvga_timing;

  localparam int FR_A = 1344 * 806;
  localparam int FR_S = 24 * 11;

  logic        vclock = 1'b0;
  logic        reset;
  logic [10:0] hc_a, hc_s;
  logic [9:0]  vc_a, vc_s;
  logic        hs_a, vs_a, bl_a, fs_a;
  logic        hs_s, vs_s, bl_s, fs_s;
`ifdef XVGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_s;
`endif

  always #5 vclock = ~vclock;

  xvga_timing dut_a (
    .vclock      (vclock),
    .reset       (reset),
    .hcount      (hc_a),
    .vcount      (vc_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .blank       (bl_a),
    .frame_start (fs_a)
`ifdef XVGA_FRAME_COUNT_EN
    ,
    .frame_count (fc_a)
`endif
  );

  xvga_timing #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6),  .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) dut_s (
    .vclock      (vclock),
    .reset       (reset),
    .hcount      (hc_s),
    .vcount      (vc_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .blank       (bl_s),
    .frame_start (fs_s)
`ifdef XVGA_FRAME_COUNT_EN
    ,
    .frame_count (fc_s)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      t_a = -1;
  longint      t_s = -1;
  logic [15:0] fcm_a = '0;
  logic [15:0] fcm_s = '0;
  bit          stats_on = 1'b0;
  int          hs_low_line1 = 0;
  int          vs_low_frame0 = 0;
  longint      last_fs_s = -1;
  longint      period_s = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected raster position is simply elapsed cycles since release, folded by line and frame length.
  task automatic check_geom(input string tag, input longint t,
                            input int ha, input int hf, input int hsw, input int hb,
                            input int va, input int vf, input int vsw, input int vb,
                            input logic [10:0] hc, input logic [9:0] vc,
                            input logic hsn, input logic vsn, input logic bl, input logic fs);
    int ht, vt, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (t < 0) begin
      h = ht - 1;
      v = vt - 1;
    end else begin
      h = int'(t % ht);
      v = int'((t / ht) % vt);
    end
    cmp({tag, ".hcount"}, 32'(hc), 32'(h));
    cmp({tag, ".vcount"}, 32'(vc), 32'(v));
    cmp({tag, ".hsync"}, 32'(hsn), (h >= ha + hf && h < ha + hf + hsw) ? 32'd0 : 32'd1);
    cmp({tag, ".vsync"}, 32'(vsn), (v >= va + vf && v < va + vf + vsw) ? 32'd0 : 32'd1);
    cmp({tag, ".blank"}, 32'(bl), (h >= ha || v >= va) ? 32'd1 : 32'd0);
    cmp({tag, ".frame_start"}, 32'(fs), (h == 0 && v == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic step();
    @(posedge vclock);
    if (!reset) begin
      t_a = -1;
      t_s = -1;
      fcm_a = '0;
      fcm_s = '0;
      last_fs_s = -1;
    end else begin
      t_a++;
      t_s++;
      if (t_a % FR_A == 0) fcm_a++;
      if (t_s % FR_S == 0) fcm_s++;
    end
    @(negedge vclock);
    check_geom("a", t_a, 1024, 24, 136, 160, 768, 3, 6, 29, hc_a, vc_a, hs_a, vs_a, bl_a, fs_a);
    check_geom("s", t_s, 16, 2, 3, 3, 6, 1, 2, 2, hc_s, vc_s, hs_s, vs_s, bl_s, fs_s);
`ifdef XVGA_FRAME_COUNT_EN
    cmp("a.frame_count", 32'(fc_a), 32'(fcm_a));
    cmp("s.frame_count", 32'(fc_s), 32'(fcm_s));
`endif
    if (stats_on) begin
      if (t_a >= 1344 && t_a < 2688 && hs_a == 1'b0) hs_low_line1++;
      if (t_s >= 0 && t_s < FR_S && vs_s == 1'b0) vs_low_frame0++;
      if (fs_s == 1'b1) begin
        if (last_fs_s >= 0 && period_s == 0) period_s = t_s - last_fs_s;
        last_fs_s = t_s;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, ".a.hcount"}, 32'(hc_a), 32'd1343);
    cmp({tag, ".a.vcount"}, 32'(vc_a), 32'd805);
    cmp({tag, ".a.hsync"}, 32'(hs_a), 32'd1);
    cmp({tag, ".a.vsync"}, 32'(vs_a), 32'd1);
    cmp({tag, ".a.blank"}, 32'(bl_a), 32'd1);
    cmp({tag, ".a.frame_start"}, 32'(fs_a), 32'd0);
    cmp({tag, ".s.hcount"}, 32'(hc_s), 32'd23);
    cmp({tag, ".s.vcount"}, 32'(vc_s), 32'd10);
    cmp({tag, ".s.blank"}, 32'(bl_s), 32'd1);
`ifdef XVGA_FRAME_COUNT_EN
    cmp({tag, ".a.frame_count"}, 32'(fc_a), 32'd0);
`endif
  endtask

  task automatic check_first_edge(input string tag);
    cmp({tag, ".a.hcount"}, 32'(hc_a), 32'd0);
    cmp({tag, ".a.vcount"}, 32'(vc_a), 32'd0);
    cmp({tag, ".a.blank"}, 32'(bl_a), 32'd0);
    cmp({tag, ".a.frame_start"}, 32'(fs_a), 32'd1);
    cmp({tag, ".s.frame_start"}, 32'(fs_s), 32'd1);
`ifdef XVGA_FRAME_COUNT_EN
    cmp({tag, ".a.frame_count"}, 32'(fc_a), 32'd1);
`endif
  endtask

  initial begin
    reset = 1'b0;
    repeat (10) begin
      step();
      check_reset_vals("init");
    end

    reset = 1'b1;
    stats_on = 1'b1;
    step();
    check_first_edge("release");
    repeat (3 * 1344) step();
    stats_on = 1'b0;
    cmp("a.hsync_low_cycles_line1", 32'(hs_low_line1), 32'd136);
    cmp("s.vsync_low_cycles_frame0", 32'(vs_low_frame0), 32'd48);
    cmp("s.frame_period", 32'(period_s), 32'd264);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(500, 11000)) step();
      #2 reset = 1'b0;
      #1 check_reset_vals("async");
      repeat ($urandom_range(1, 5)) step();
      reset = 1'b1;
      step();
      check_first_edge("restart");
    end

`ifdef XVGA_FRAME_COUNT_EN
    force dut_s.frame_count = 16'hFFFF;
    fcm_s = 16'hFFFF;
    #1 release dut_s.frame_count;
    repeat (FR_S + 40) step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
